qmem_decoder_amap: RTL
======================

Name: qmem_decoder_amap

Overview:
Next-generation qmem 1-to-SN decoder. Slave selection comes from an internal parametrised address map, so no external one-hot select is needed.
- Unmapped addresses get a decoder-generated error response.
- A per-transfer watchdog aborts hung slave accesses.
- Error status (cause, address, count) is kept for the control CPU.
- Sits between a qmem master (CPU/ctrl) and its peripherals/memories.

Parameters:
QAW, 32, address width
QDW, 32, data width
QSW, QDW/8, byte-select width
SN, 4, slave count (1..16)
SLV_BASE, SN*QAW bits, packed base addresses; slave i at [QAW*i +: QAW]
SLV_MASK, SN*QAW bits, packed decode masks; same packing
TOW, 8, timeout counter width
TO, 255, timeout in cycles; 0 disables the watchdog
ECW, 8, error counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
qm_cs/qm_we  in  1/1  master request, write enable
qm_adr  in  QAW  master address
qm_sel  in  QSW  byte selects
qm_dat_w  in  QDW  write data
qm_dat_r  out  QDW  read data
qm_ack/qm_err  out  1/1  master acknowledge / error
qs_cs/qs_we  out  SN/SN  per-slave chip select / write enable
qs_adr/qs_sel/qs_dat_w  out  SN*QAW/SN*QSW/SN*QDW  broadcast to every slave
qs_dat_r  in  SN*QDW  slave read data
qs_ack/qs_err  in  SN/SN  slave acknowledge / error
err_clr  in  1  clears error status
err_code  out  2  0 none, 1 decode, 2 timeout, 3 slave err
err_adr  out  QAW  address of the last error
err_cnt  out  ECW  saturating error count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; timeout counter 0; read-select = NONE; err_code 0, err_adr 0, err_cnt 0; qm_dat_r 0.
  - All qs_cs, qm_ack and qm_err are 0 whenever qm_cs=0.
- Address decode (combinational):
  - Slave i hits if (qm_adr & MASK_i) == BASE_i.
  - The lowest index wins when several slaves hit.
  - hit = OR of all matches; idx = index of the winning slave.
- Broadcast: qs_we, qs_adr, qs_sel and qs_dat_w are copied unchanged to every slave.
- qs_cs[i] = qm_cs & hit & idx==i & state is IDLE or WAIT.
- qm_ack and qm_err: in IDLE/WAIT they follow qs_ack[idx] / qs_err[idx] combinationally; zero-latency slaves complete in the same cycle.
- State machine:
  - IDLE, qm_cs & hit:
    - If ack or err arrives the same cycle, stay in IDLE.
    - Otherwise go to WAIT and set the counter to 1.
  - IDLE, qm_cs & !hit:
    - Go to DERR. qm_ack and qm_err stay 0 this cycle. No slave is selected.
  - WAIT:
    - Counter increments each cycle.
    - ack or err → IDLE, counter cleared.
    - If TO != 0 and counter == TO with no ack/err → TOUT.
    - qm_cs dropping (protocol violation) → IDLE, counter cleared, nothing recorded.
  - DERR: if qm_cs is still 1, qm_err=1 for exactly one cycle. Next state IDLE.
  - TOUT: qs_cs forced to 0 (abort) and qm_err=1 for one cycle. Next state IDLE.
- Collision rules:
  - ack in the same cycle the counter reaches TO: ack wins, no timeout.
  - Slave ack and err asserted together are both passed through; the error is recorded.
- Read data:
  - On any completed read (qm_cs & ~qm_we & (qm_ack|qm_err)), read-select <= idx for slave completions, or NONE for DERR/TOUT.
  - qm_dat_r = qs_dat_r slice of read-select. NONE returns 0.
  - Data is valid the cycle after ack, as required by the qmem protocol.
  - Writes leave read-select unchanged.
- Error status:
  - Updated on the cycle qm_err=1: err_code and err_adr <= qm_adr; err_cnt increments and saturates at all-ones.
  - err_clr zeroes all three. If err_clr and a new error happen in the same cycle, the new error is recorded and err_cnt = 1.
- Reset asserted mid-transfer: all state returns to reset values immediately. No ack or err is generated for the aborted transfer.

Decomposition:
- qmem_pkg holds:
  - error-code constants ERR_NONE/DEC/TOUT/SLV;
  - the state encoding IDLE/WAIT/DERR/TOUT;
  - the NONE select constant, equal to SN.
- Sub-module qmem_addr_match: parametrised priority matcher with inputs qm_adr, SLV_BASE, SLV_MASK and outputs hit, idx [$clog2(SN+1)], onehot [SN].

Test Plan:
- Map SN=2 (BASE0=0x0000_0000 MASK0=0xF000_0000; BASE1=0x1000_0000 MASK1=0xF000_0000). Read 0x1000_0040, slave 1 acks in the same cycle with data 0xCAFEBABE → qs_cs=2'b10, qm_ack in the same cycle, qm_dat_r=0xCAFEBABE the next cycle, no WAIT state.
- Write to 0x2000_0000 → qs_cs=0; qm_err=1 exactly in the 2nd cycle; err_code=1, err_adr=0x2000_0000, err_cnt=1; a following read gives qm_dat_r=0.
- TO=4, slave 0 never acks → qm_err on the cycle after the counter reaches 4, qs_cs deasserted that cycle, err_code=2, err_cnt=2 after a repeat.
- TO=4, slave acks on the exact timeout cycle → qm_ack=1, qm_err=0, err_cnt unchanged.
- Overlapping map: slaves 0 and 1 both match 0x0 → only qs_cs[0] asserted. err_clr together with a slave qs_err → err_cnt=1, err_code=3.
- rst pulsed while in WAIT → state IDLE, outputs zero immediately; a subsequent normal access completes correctly.

Source files
------------

// File: rtl/qmem_pkg.sv
// Shared constants for the qmem address-mapped decoder: error codes, FSM
// encoding and the "no slave" read-select value.
package qmem_pkg;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DEC  = 2'd1;
    localparam logic [1:0] ERR_TOUT = 2'd2;
    localparam logic [1:0] ERR_SLV  = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DERR = 2'd2;
    localparam logic [1:0] TOUT = 2'd3;

    // Read-select value meaning "no slave"; one past the last slave index.
    function automatic int sel_none(input int sn);
        return sn;
    endfunction

endpackage

// File: rtl/qmem_decoder_amap_if.sv
// qmem bus bundle. N=1 models the single master link, N=SN the fan-out to the
// slaves; every field is packed per lane.
interface qmem_decoder_amap_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int N  = 1
);
    localparam int SW = DW / 8;

    logic [N-1:0]    cs;
    logic [N-1:0]    we;
    logic [N*AW-1:0] adr;
    logic [N*SW-1:0] sel;
    logic [N*DW-1:0] dat_w;
    logic [N*DW-1:0] dat_r;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;

    modport master (
        output cs, we, adr, sel, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cs, we, adr, sel, dat_w,
        output dat_r, ack, err
    );

endinterface

// File: rtl/qmem_addr_match.sv
// Priority address matcher: slave i hits when (adr & MASK_i) == BASE_i, the
// lowest hitting index wins. idx is SN (no slave) when nothing hits.
module qmem_addr_match #(
    parameter int QAW = 32,
    parameter int SN  = 4,
    parameter int IW  = $clog2(SN + 1)
) (
    input  logic [QAW-1:0]    qm_adr,
    input  logic [SN*QAW-1:0] slv_base,
    input  logic [SN*QAW-1:0] slv_mask,
    output logic              hit,
    output logic [IW-1:0]     idx,
    output logic [SN-1:0]     onehot
);

    logic [SN-1:0] match_s;

    // Per-slave compare, then a downward scan so the lowest index is kept last.
    always_comb begin
        match_s = '0;
        idx     = IW'(SN);
        onehot  = '0;
        for (int i = 0; i < SN; i++) begin
            match_s[i] = ((qm_adr & slv_mask[i*QAW +: QAW]) == slv_base[i*QAW +: QAW]);
        end
        for (int i = SN - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                idx       = IW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end else begin
                idx       = idx;
            end
        end
        hit = |match_s;
    end

endmodule

// File: rtl/qmem_decoder_amap.sv
// qmem 1-to-SN decoder with internal address map, decode-error response,
// per-transfer watchdog and error status registers for the control CPU.
module qmem_decoder_amap
    import qmem_pkg::*;
#(
    parameter int              QAW      = 32,
    parameter int              QDW      = 32,
    parameter int              QSW      = QDW / 8,
    parameter int              SN       = 4,
    parameter logic [SN*QAW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [SN*QAW-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int              TOW      = 8,
    parameter int              TO       = 255,
    parameter int              ECW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    qmem_decoder_amap_if.slave   qm,
    qmem_decoder_amap_if.master  qs,
    input  logic                 err_clr,
    output logic [1:0]           err_code,
    output logic [QAW-1:0]       err_adr,
    output logic [ECW-1:0]       err_cnt
);

    localparam int             IW     = $clog2(SN + 1);
    localparam logic [IW-1:0]  NONE_C = IW'(sel_none(SN));
    localparam logic [TOW-1:0] TO_C   = TOW'(TO);

    logic            hit_s;
    logic [IW-1:0]   idx_s;
    logic [SN-1:0]   onehot_s;
    logic            act_s;
    logic            s_ack_s;
    logic            s_err_s;
    logic            ack_s;
    logic            err_s;
    logic [QDW-1:0]  dat_r_s;

    logic [1:0]      state_q,    state_d;
    logic [TOW-1:0]  cnt_q,      cnt_d;
    logic [IW-1:0]   rsel_q,     rsel_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [QAW-1:0]  err_adr_q,  err_adr_d;
    logic [ECW-1:0]  err_cnt_q,  err_cnt_d;

    qmem_addr_match #(
        .QAW (QAW),
        .SN  (SN),
        .IW  (IW)
    ) u_match (
        .qm_adr   (qm.adr),
        .slv_base (SLV_BASE),
        .slv_mask (SLV_MASK),
        .hit      (hit_s),
        .idx      (idx_s),
        .onehot   (onehot_s)
    );

    // Request routing and master response; slave responses pass through in IDLE/WAIT.
    always_comb begin
        act_s   = (state_q == IDLE) || (state_q == WAIT);
        s_ack_s = |(qs.ack & onehot_s);
        s_err_s = |(qs.err & onehot_s);
        if (qm.cs[0] && act_s) begin
            qs.cs = onehot_s;
            ack_s = s_ack_s;
            err_s = s_err_s;
        end else if (qm.cs[0] && ((state_q == DERR) || (state_q == TOUT))) begin
            qs.cs = '0;
            ack_s = 1'b0;
            err_s = 1'b1;
        end else begin
            qs.cs = '0;
            ack_s = 1'b0;
            err_s = 1'b0;
        end
    end

    assign qs.we    = {SN{qm.we[0]}};
    assign qs.adr   = {SN{qm.adr}};
    assign qs.sel   = {SN{qm.sel}};
    assign qs.dat_w = {SN{qm.dat_w}};
    assign qm.ack   = ack_s;
    assign qm.err   = err_s;

    // Transfer FSM with watchdog; an ack on the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!qm.cs[0]) begin
                    state_d = IDLE;
                end else if (!hit_s) begin
                    state_d = DERR;
                end else if (s_ack_s || s_err_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = TOW'(1);
                end
            end
            WAIT: begin
                if (!qm.cs[0] || s_ack_s || s_err_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((TO != 0) && (cnt_q == TO_C)) begin
                    state_d = TOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + TOW'(1);
                end
            end
            DERR, TOUT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read-select and error status updates; a new error beats a same-cycle clear.
    always_comb begin
        rsel_d     = rsel_q;
        err_code_d = err_code_q;
        err_adr_d  = err_adr_q;
        err_cnt_d  = err_cnt_q;
        if (qm.cs[0] && !qm.we[0] && (ack_s || err_s)) begin
            rsel_d = act_s ? idx_s : NONE_C;
        end else begin
            rsel_d = rsel_q;
        end
        if (err_s) begin
            err_code_d = act_s ? ERR_SLV : ((state_q == DERR) ? ERR_DEC : ERR_TOUT);
            err_adr_d  = qm.adr;
            if (err_clr) begin
                err_cnt_d = ECW'(1);
            end else if (err_cnt_q == {ECW{1'b1}}) begin
                err_cnt_d = err_cnt_q;
            end else begin
                err_cnt_d = err_cnt_q + ECW'(1);
            end
        end else if (err_clr) begin
            err_code_d = ERR_NONE;
            err_adr_d  = '0;
            err_cnt_d  = '0;
        end else begin
            err_code_d = err_code_q;
        end
    end

    // Read data mux; the NONE select falls through to zero.
    always_comb begin
        dat_r_s = '0;
        for (int i = 0; i < SN; i++) begin
            if (rsel_q == IW'(i)) begin
                dat_r_s = qs.dat_r[i*QDW +: QDW];
            end else begin
                dat_r_s = dat_r_s;
            end
        end
    end

    assign qm.dat_r = dat_r_s;
    assign err_code = err_code_q;
    assign err_adr  = err_adr_q;
    assign err_cnt  = err_cnt_q;

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsel_q     <= NONE_C;
            err_code_q <= ERR_NONE;
            err_adr_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsel_q     <= rsel_d;
            err_code_q <= err_code_d;
            err_adr_q  <= err_adr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
